// File: rtl/sram_mem_responder.sv
// -----------------------------------------------------------------------------
// sram_mem_responder
//
// Memory-side responder for MEM-stage LDR/STR requests. One 32-bit word
// request is turned into two 16-bit accesses on the external SRAM bus: the low
// halfword first, then the high halfword. Each halfword phase holds address
// and data on the bus for PHASE_CYCLES cycles. ready is held low while a
// transfer is in flight. The pipeline freezes on ready=0 and keeps its request
// stable until ready returns high.
//
// Parameters
//   BASE_ADDR    byte address that maps to SRAM word 0
//   SRAM_ADDR_W  external SRAM address width, in halfword units
//   PHASE_CYCLES bus cycles per halfword phase (1..15)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   rd_en        load request from the MEM stage
//   wr_en        store request from the MEM stage (wins over rd_en)
//   address      byte address; bits [1:0] are ignored
//   write_data   store data
//   read_data    registered load data
//   ready        1 = idle or completing this cycle; 0 = pipeline must freeze
//   sram_addr    halfword address to the SRAM
//   sram_dq_out  halfword to write
//   sram_dq_in   halfword read back from the SRAM
//   sram_dq_oe   1 = drive sram_dq_out onto the bus
//   sram_we_n    SRAM write strobe, active low
// -----------------------------------------------------------------------------
module sram_mem_responder #(
  parameter int unsigned BASE_ADDR    = 1024,
  parameter int unsigned SRAM_ADDR_W  = 18,
  parameter int unsigned PHASE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  localparam int unsigned WORD_W = SRAM_ADDR_W - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [31:0] BASE     = 32'(BASE_ADDR);
  // Window bounds are kept at 33 bits so the upper limit cannot wrap when
  // BASE_ADDR sits near the top of the 32-bit space.
  localparam logic [32:0] LO_BOUND = 33'(BASE_ADDR);
  localparam logic [32:0] HI_BOUND = 33'(BASE_ADDR) + (33'd1 << (SRAM_ADDR_W + 1));
  localparam logic [3:0]  LAST_CNT = 4'(PHASE_CYCLES - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              op_wr;
  logic [WORD_W-1:0] word_q;
  logic [31:0]       wdata_q;
  logic [15:0]       lo_q;

  logic              in_range;
  logic              start;
  logic              last_cycle;
  logic [WORD_W-1:0] req_word;

  // Request decode: window check and byte-to-word translation.
  assign in_range   = ({1'b0, address} >= LO_BOUND) && ({1'b0, address} < HI_BOUND);
  assign req_word   = WORD_W'((address - BASE) >> 2);
  assign start      = (rd_en | wr_en) & in_range;
  assign last_cycle = (cnt == LAST_CNT);

  // ready drops in the same cycle a request is first seen, so the pipeline
  // freezes without a cycle of slip. While reset is held nothing can start,
  // so ready reports idle regardless of the request lines.
  always_comb begin
    ready = 1'b0;
    if (!rst) begin
      ready = 1'b1;
    end else begin
      case (state)
        ST_IDLE: ready = ~start;
        ST_DONE: ready = 1'b1;
        default: ready = 1'b0;
      endcase
    end
  end

  // Transfer sequencer. SRAM bus outputs are only updated on phase
  // boundaries, so address/data/strobe stay stable for a whole phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      op_wr       <= 1'b0;
      word_q      <= '0;
      wdata_q     <= 32'd0;
      lo_q        <= 16'd0;
      read_data   <= 32'd0;
      sram_addr   <= '0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            // A combined rd_en/wr_en request is served as a store.
            op_wr      <= wr_en;
            word_q     <= req_word;
            wdata_q    <= write_data;
            cnt        <= 4'd0;
            state      <= ST_LOW;
            sram_addr  <= {req_word, 1'b0};
            sram_dq_oe <= wr_en;
            sram_we_n  <= ~wr_en;
            if (wr_en) begin
              sram_dq_out <= write_data[15:0];
            end
          end
        end

        ST_LOW: begin
          if (last_cycle) begin
            if (!op_wr) begin
              lo_q <= sram_dq_in;
            end
            cnt        <= 4'd0;
            state      <= ST_HIGH;
            sram_addr  <= {word_q, 1'b1};
            sram_dq_oe <= op_wr;
            sram_we_n  <= ~op_wr;
            if (op_wr) begin
              sram_dq_out <= wdata_q[31:16];
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        ST_HIGH: begin
          if (last_cycle) begin
            if (!op_wr) begin
              read_data <= {sram_dq_in, lo_q};
            end
            cnt        <= 4'd0;
            state      <= ST_DONE;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        default: begin
          // DONE: the request still on the inputs is the one just served.
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_responder.sv
module tb_sram_mem_responder;

  localparam int unsigned P      = 2;
  localparam int unsigned BASE   = 1024;
  localparam int unsigned AW     = 18;
  localparam int          NVEC   = 9;
  localparam int          BUDGET = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [31:0]   address = 32'd0;
  logic [31:0]   write_data = 32'd0;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic [15:0]   sram_dq_in;
  logic          sram_dq_oe;
  logic          sram_we_n;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  sram_mem_responder #(
    .BASE_ADDR   (BASE),
    .SRAM_ADDR_W (AW),
    .PHASE_CYCLES(P)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // SRAM model: preloaded with a per-address pattern, written on a clock edge
  // while the write strobe is low, read asynchronously.
  logic [15:0] mem [0:(1<<AW)-1];
  bit          mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 16'(i) ^ 16'hA5A5;
      mem_init <= 1'b1;
    end else if (!sram_we_n) begin
      mem[sram_addr] <= sram_dq_out;
    end
  end

  assign sram_dq_in = mem[sram_addr];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_stall;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  typedef struct {
    int          stall;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drives one request just after a rising edge, follows it to ready, checks
  // the SRAM bus every stall cycle, then drops the request after the edge
  // that ends the completing cycle.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input string name,
                         output int stall, output logic [31:0] rdata, output int done_cyc);
    logic [16:0] word;
    logic        hi;
    word       = 17'((addr - 32'(BASE)) >> 2);
    rd_en      = rd;
    wr_en      = wr;
    address    = addr;
    write_data = wd;
    stall      = 0;
    @(negedge clk);
    while (!ready && stall < BUDGET) begin
      if (stall >= 1) begin
        hi = (stall > int'(P));
        check({name, " addr"}, 32'(sram_addr), 32'({word, hi}));
        if (wr) begin
          check({name, " we_n"}, 32'(sram_we_n), 32'd0);
          check({name, " oe"},   32'(sram_dq_oe), 32'd1);
          check({name, " dq"},   32'(sram_dq_out), hi ? 32'(wd[31:16]) : 32'(wd[15:0]));
        end else begin
          check({name, " we_n"}, 32'(sram_we_n), 32'd1);
          check({name, " oe"},   32'(sram_dq_oe), 32'd0);
        end
      end
      stall++;
      @(negedge clk);
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=ready_low expected=ready_high", name);
    end
    rdata    = read_data;
    done_cyc = cycle;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    int          stall;
    int          dc_w;
    int          dc_r;
    logic [31:0] rdata;
    logic [AW-1:0] prev_addr;
    exp_t        e;

    vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 5, 32'h00000000, "wr1028"};
    vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        5, 32'hDEADBEEF, "rd1028"};
    vecs[2] = '{1'b1, 1'b0, 32'h10,   32'h0,        0, 32'hDEADBEEF, "rd_oor_low"};
    vecs[3] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 5, 32'hDEADBEEF, "rdwr1024"};
    vecs[4] = '{1'b1, 1'b0, 32'd1024, 32'h0,        5, 32'h12345678, "rd1024"};
    vecs[5] = '{1'b1, 1'b0, 32'd1046, 32'h0,        5, 32'hA5AEA5AF, "rd1044_pre"};
    vecs[6] = '{1'b1, 1'b0, 32'd525308, 32'h0,      5, 32'h5A5A5A5B, "rd_top"};
    vecs[7] = '{1'b1, 1'b0, 32'd525312, 32'h0,      0, 32'h5A5A5A5B, "rd_oor_high"};
    vecs[8] = '{1'b0, 1'b1, 32'd1020, 32'h77777777, 0, 32'h5A5A5A5B, "wr_oor_below"};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", 32'(ready), 32'd1);
    check("rst rdata", read_data, 32'd0);
    check("rst we_n", 32'(sram_we_n), 32'd1);
    check("rst oe", 32'(sram_dq_oe), 32'd0);
    check("rst addr", 32'(sram_addr), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      sb.push_back('{vecs[i].exp_stall, vecs[i].exp_rdata, vecs[i].name});
      prev_addr = sram_addr;
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].name,
              stall, rdata, dc_w);
      e = sb.pop_front();
      check({e.name, " stall"}, 32'(stall), 32'(e.stall));
      check({e.name, " rdata"}, rdata, e.rdata);
      @(negedge clk);
      if (e.stall == 0) begin
        check({e.name, " addr_hold"}, 32'(sram_addr), 32'(prev_addr));
        check({e.name, " we_n_idle"}, 32'(sram_we_n), 32'd1);
      end else begin
        check({e.name, " oe_after"}, 32'(sram_dq_oe), 32'd0);
      end
      @(posedge clk);
      #1;
    end

    check("mem hw0", 32'(mem[0]), 32'h5678);
    check("mem hw1", 32'(mem[1]), 32'h1234);
    check("mem hw2", 32'(mem[2]), 32'hBEEF);
    check("mem hw3", 32'(mem[3]), 32'hDEAD);

    // Back-to-back: read issued in the IDLE cycle right after the write's DONE
    sb.push_back('{5, 32'h5A5A5A5B, "b2b_wr"});
    run_txn(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, "b2b_wr", stall, rdata, dc_w);
    e = sb.pop_front();
    check({e.name, " stall"}, 32'(stall), 32'(e.stall));
    check({e.name, " rdata"}, rdata, e.rdata);
    sb.push_back('{5, 32'hCAFEF00D, "b2b_rd"});
    run_txn(1'b1, 1'b0, 32'd1032, 32'h0, "b2b_rd", stall, rdata, dc_r);
    e = sb.pop_front();
    check({e.name, " stall"}, 32'(stall), 32'(e.stall));
    check({e.name, " rdata"}, rdata, e.rdata);
    check("b2b gap", 32'(dc_r - dc_w), 32'd6);

    // Asynchronous reset in the middle of the low phase of a write
    rd_en      = 1'b0;
    wr_en      = 1'b1;
    address    = 32'd1036;
    write_data = 32'h11112222;
    @(posedge clk);
    #1;
    check("midrst started we_n", 32'(sram_we_n), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("midrst we_n", 32'(sram_we_n), 32'd1);
    check("midrst oe", 32'(sram_dq_oe), 32'd0);
    check("midrst ready", 32'(ready), 32'd1);
    check("midrst rdata", read_data, 32'd0);
    check("midrst addr", 32'(sram_addr), 32'd0);
    wr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check("midrst hw6", 32'(mem[6]), 32'hA5A3);
    check("midrst hw7", 32'(mem[7]), 32'hA5A2);
    @(posedge clk);
    #1;
    sb.push_back('{5, 32'hA5A2A5A3, "after_rst_rd"});
    run_txn(1'b1, 1'b0, 32'd1036, 32'h0, "after_rst_rd", stall, rdata, dc_r);
    e = sb.pop_front();
    check({e.name, " stall"}, 32'(stall), 32'(e.stall));
    check({e.name, " rdata"}, rdata, e.rdata);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
